// File: rtl/bc_fifo_stream16x8_if.sv
// Push port plus valid/ready read stream for the 16x8 stream FIFO.
// slave = FIFO side, master = producer/consumer side.
interface bc_fifo_stream16x8_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             wr;
  logic [WIDTH-1:0] di;
  logic             full;
  logic             afull;
  logic             rdy;
  logic             dv;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic [AW:0]      level;
  logic             ovf;

  modport master (
    output wr, di, rdy,
    input  full, afull, dv, dout,
    input  empty, level, ovf
  );

  modport slave (
    input  wr, di, rdy,
    output full, afull, dv, dout,
    output empty, level, ovf
  );
endinterface

// File: rtl/bc_fifo_stream16x8.sv
// FIFO on a 2**AW x WIDTH LUT RAM with a registered dv/dout read stream.
// Ports: clk, rst (async high), bus (slave). Macro BC_FIFO_OVF_EN adds sticky ovf.
module bc_fifo_stream16x8 #(
  parameter int WIDTH     = 8,
  parameter int AW        = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic                clk,
  input  logic                rst,
  bc_fifo_stream16x8_if.slave bus
);
  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AF   = (AW+1)'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             dv_q, dv_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full, empty, push, ld;

  always_comb begin
    full    = (level_q == LVL_FULL);
    empty   = (level_q == '0);
    push    = bus.wr & ~full;
    // refill output reg when it is free or being taken
    ld      = ~empty & (~dv_q | bus.rdy);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    dv_d    = dv_q;
    dout_d  = dout_q;
    if (push)
      wptr_d = wptr_q + 1'b1;
    if (ld) begin
      rptr_d = rptr_q + 1'b1;
      dv_d   = 1'b1;
      dout_d = mem[rptr_q];
    end else if (dv_q & bus.rdy) begin
      dv_d   = 1'b0;
    end
    unique case ({push, ld})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // RAM is not reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr_q] <= bus.di;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
    end
  end

`ifdef BC_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.wr & full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.afull = (level_q >= LVL_AF);
  assign bus.level = level_q;
  assign bus.dv    = dv_q;
  assign bus.dout  = dout_q;
endmodule
